// File: rtl/video_pkg.sv
// Shared types and constants for the text-mode video path.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHAR,
        ATTR,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] chr;
    } pair_t;

    localparam logic [7:0] COLS_40 = 8'd40;
    localparam logic [7:0] COLS_80 = 8'd80;

endpackage

// File: rtl/cga_text_fetch_if.sv
// Command, video RAM port B and renderer stream signals of the text fetch engine.
interface cga_text_fetch_if #(
    parameter int AW = 16
);
    logic          fetch_start;
    logic [AW-1:0] start_addr;
    logic [7:0]    col_count;
    logic          flush;
    logic          busy;
    logic          done;
    logic          vram_en;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_dout;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_char;
    logic [7:0]    out_attr;

    modport master (
        input  fetch_start, start_addr, col_count, flush, vram_dout, out_ready,
        output busy, done, vram_en, vram_addr, out_valid, out_char, out_attr
    );

    modport slave (
        output fetch_start, start_addr, col_count, flush, vram_dout, out_ready,
        input  busy, done, vram_en, vram_addr, out_valid, out_char, out_attr
    );
endinterface

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of character/attribute pairs with synchronous flush.
module fetch_fifo
    import video_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  pair_t                        push_data,
    input  logic                         pop,
    output pair_t                        head,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    pair_t          mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_pop;

    assign do_pop = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // Forcing the head to zero while empty keeps the outputs stable and zero after reset.
    assign valid = (count != '0);
    assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/cga_text_fetch.sv
// Per-line character/attribute fetch from video RAM port B into a small output FIFO.
module cga_text_fetch
    import video_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    cga_text_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    fetch_state_t   state;
    logic [AW-1:0]  ptr;
    logic [AW-1:0]  vram_addr_q;
    logic [7:0]     remaining;
    logic [7:0]     char_q;
    logic           attr_pending;
    logic           busy_q;
    logic           done_q;
    logic           vram_en_q;

    logic           fifo_valid;
    logic           pop;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    count_next;
    logic           space_fresh;
    logic           space_after_attr;
    pair_t          push_data;
    pair_t          head;

    assign push_data = '{attr: bus.vram_dout, chr: char_q};
    assign pop       = fifo_valid & bus.out_ready;

    // vram_en is registered, so the space check looks at next cycle's occupancy,
    // counting a pair whose attribute byte will still be in flight.
    assign count_next       = {1'b0, fifo_count} + (CW+1)'(attr_pending) - (CW+1)'(pop);
    assign space_fresh      = count_next < DEPTH_W;
    assign space_after_attr = (count_next + (CW+1)'(1)) < DEPTH_W;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            state        <= IDLE;
            ptr          <= '0;
            remaining    <= '0;
            char_q       <= '0;
            attr_pending <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vram_en_q    <= 1'b0;
            vram_addr_q  <= '0;
        end else begin
            done_q       <= 1'b0;
            attr_pending <= 1'b0;
            vram_en_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.fetch_start) begin
                        if (bus.col_count != 8'd0) begin
                            state       <= CHAR;
                            busy_q      <= 1'b1;
                            ptr         <= bus.start_addr;
                            remaining   <= bus.col_count;
                            vram_en_q   <= space_fresh;
                            vram_addr_q <= bus.start_addr;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                CHAR: begin
                    if (vram_en_q) begin
                        state       <= ATTR;
                        vram_en_q   <= 1'b1;
                        vram_addr_q <= ptr + AW'(1);
                    end else begin
                        vram_en_q   <= space_fresh;
                        vram_addr_q <= ptr;
                    end
                end
                ATTR: begin
                    char_q       <= bus.vram_dout;
                    attr_pending <= 1'b1;
                    ptr          <= ptr + AW'(2);
                    remaining    <= remaining - 8'd1;
                    vram_addr_q  <= ptr + AW'(2);
                    if (remaining != 8'd1) begin
                        state     <= CHAR;
                        vram_en_q <= space_after_attr;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .push      (attr_pending),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.vram_en   = vram_en_q;
    assign bus.vram_addr = vram_addr_q;
    assign bus.out_valid = fifo_valid;
    assign bus.out_char  = head.chr;
    assign bus.out_attr  = head.attr;

endmodule
